// File: rtl/pacman_mover_if.sv
// pacman_mover_if
//   Groups the movement controller's player/maze inputs and sprite outputs.
//   slave  : the pacman_mover side (consumes buttons and leg flags).
//   master : the driving side (buttons, legal-move lookup, sprite consumer).
//   Signals:
//     btn_l/r/u/d : direction buttons, level or pulse
//     leg_l/r/u/d : legal-move flags for the tile at the current xpos/ypos
//     xpos, ypos  : sprite top-left pixel (10 bits)
//     dir         : heading, 0=L 1=R 2=U 3=D
//     moving      : high while in the MOVING state
//     step        : one-cycle pulse on every cycle the position changes
//     dbg_state   : raw FSM state for debug/checkers (0=IDLE 1=MOVING 2=BLOCKED)
interface pacman_mover_if;
    logic       btn_l;
    logic       btn_r;
    logic       btn_u;
    logic       btn_d;
    logic       leg_l;
    logic       leg_r;
    logic       leg_u;
    logic       leg_d;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic [1:0] dir;
    logic       moving;
    logic       step;
    logic [1:0] dbg_state;

    modport slave (
        input  btn_l, btn_r, btn_u, btn_d,
        input  leg_l, leg_r, leg_u, leg_d,
        output xpos, ypos, dir, moving, step, dbg_state
    );

    modport master (
        output btn_l, btn_r, btn_u, btn_d,
        output leg_l, leg_r, leg_u, leg_d,
        input  xpos, ypos, dir, moving, step, dbg_state
    );
endinterface

// File: rtl/pacman_mover.sv
// pacman_mover
//   Pac-Man movement controller. Owns the sprite position, drives it into the
//   combinational legal-move lookup and uses the returned leg flags in the same
//   cycle. Buffers the player's turn request and commits turns only when the
//   sprite is tile-aligned; mid-tile only an immediate reversal is accepted.
//   Ports:
//     clk   : system clock
//     reset : synchronous, active-high reset
//     bus   : pacman_mover_if.slave (buttons, leg flags, position/heading out)
//   Optional feature: define PACMAN_TUNNEL_WRAP_EN to make the left/right maze
//   edges a wrap-around tunnel; otherwise the edges act as walls.
module pacman_mover #(
    parameter int START_X  = 306,
    parameter int START_Y  = 310,
    parameter int ORIGIN_X = 150,
    parameter int ORIGIN_Y = 34,
    parameter int TILE     = 12,
    parameter int COLS     = 28,
    parameter int TICK_DIV = 4
) (
    input logic           clk,
    input logic           reset,
    pacman_mover_if.slave bus
);
    localparam int SW = (TILE > 1) ? $clog2(TILE) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [SW-1:0] SUB_MAX  = SW'(TILE - 1);
    localparam logic [TW-1:0] TCNT_MAX = TW'(TICK_DIV - 1);
    localparam logic [9:0]    X_RESET  = 10'(START_X);
    localparam logic [9:0]    Y_RESET  = 10'(START_Y);
    localparam logic [9:0]    X_LEFT   = 10'(ORIGIN_X);
    localparam logic [9:0]    X_RIGHT  = 10'(ORIGIN_X + COLS * TILE - 1);

    localparam logic [1:0] D_L = 2'd0;
    localparam logic [1:0] D_R = 2'd1;
    localparam logic [1:0] D_U = 2'd2;
    localparam logic [1:0] D_D = 2'd3;

    // A misaligned start would leave the sub-tile counters out of step with xpos/ypos.
    if (((START_X - ORIGIN_X) % TILE != 0) || ((START_Y - ORIGIN_Y) % TILE != 0)) begin : g_bad_start
        $error("pacman_mover: START_X/START_Y must be tile-aligned");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MOVING  = 2'd1,
        S_BLOCKED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    xpos_q, xpos_d, ypos_q, ypos_d;
    logic [SW-1:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [1:0]    dir_q, dir_d, req_dir_q, req_dir_d, btn_dir;
    logic          req_v_q, req_v_d, step_q;
    logic          tick, aligned, any_btn, commit, do_step;
    logic          edge_l, edge_r, wrap_l, wrap_r;
    logic [3:0]    legs;

    assign tick    = (tcnt_q == TCNT_MAX);
    assign aligned = (sub_x_q == '0) && (sub_y_q == '0);
    assign tcnt_d  = tick ? '0 : tcnt_q + 1'b1;

`ifdef PACMAN_TUNNEL_WRAP_EN
    assign edge_l = 1'b0;
    assign edge_r = 1'b0;
    assign wrap_l = aligned && (xpos_q == X_LEFT);
    // Only reachable while travelling right, and x = X_RIGHT is never aligned.
    assign wrap_r = (xpos_q == X_RIGHT);
`else
    localparam logic [9:0] X_LAST = 10'(ORIGIN_X + (COLS - 1) * TILE);
    // Maze edges are hard walls whatever the lookup says.
    assign edge_l = aligned && (xpos_q == X_LEFT);
    assign edge_r = aligned && (xpos_q == X_LAST);
    assign wrap_l = 1'b0;
    assign wrap_r = 1'b0;
`endif

    // Indexed by direction code: bit0=L, bit1=R, bit2=U, bit3=D.
    assign legs = {bus.leg_d, bus.leg_u, bus.leg_r & ~edge_r, bus.leg_l & ~edge_l};

    // Button priority L > R > U > D.
    assign any_btn = bus.btn_l | bus.btn_r | bus.btn_u | bus.btn_d;
    always_comb begin
        btn_dir = D_D;
        if (bus.btn_l)      btn_dir = D_L;
        else if (bus.btn_r) btn_dir = D_R;
        else if (bus.btn_u) btn_dir = D_U;
    end

    // A button seen this cycle wins over the commit clear, so a held button re-arms.
    assign req_v_d   = any_btn ? 1'b1 : (commit ? 1'b0 : req_v_q);
    assign req_dir_d = any_btn ? btn_dir : req_dir_q;

    // Next-state and turn/step decisions; everything happens only on ticks.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        commit  = 1'b0;
        do_step = 1'b0;
        if (tick) begin
            case (state_q)
                S_IDLE, S_BLOCKED: begin
                    if (req_v_q && legs[req_dir_q]) begin
                        dir_d   = req_dir_q;
                        commit  = 1'b1;
                        do_step = 1'b1;
                        state_d = S_MOVING;
                    end
                end
                S_MOVING: begin
                    if (!aligned) begin
                        // Opposite heading differs only in bit 0 (L/R, U/D).
                        if (req_v_q && (req_dir_q == (dir_q ^ 2'd1))) begin
                            dir_d  = req_dir_q;
                            commit = 1'b1;
                        end
                        do_step = 1'b1;
                    end else begin
                        if (req_v_q && legs[req_dir_q]) begin
                            dir_d  = req_dir_q;
                            commit = 1'b1;
                        end
                        if (legs[dir_d]) do_step = 1'b1;
                        else             state_d = S_BLOCKED;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // One-pixel step with the sub-tile offset tracking alongside.
    always_comb begin
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        sub_x_d = sub_x_q;
        sub_y_d = sub_y_q;
        if (do_step) begin
            case (dir_d)
                D_L: begin
                    if (wrap_l) begin
                        xpos_d  = X_RIGHT;
                        sub_x_d = SUB_MAX;
                    end else begin
                        xpos_d  = xpos_q - 10'd1;
                        sub_x_d = (sub_x_q == '0) ? SUB_MAX : sub_x_q - 1'b1;
                    end
                end
                D_R: begin
                    if (wrap_r) begin
                        xpos_d  = X_LEFT;
                        sub_x_d = '0;
                    end else begin
                        xpos_d  = xpos_q + 10'd1;
                        sub_x_d = (sub_x_q == SUB_MAX) ? '0 : sub_x_q + 1'b1;
                    end
                end
                D_U: begin
                    ypos_d  = ypos_q - 10'd1;
                    sub_y_d = (sub_y_q == '0) ? SUB_MAX : sub_y_q - 1'b1;
                end
                default: begin
                    ypos_d  = ypos_q + 10'd1;
                    sub_y_d = (sub_y_q == SUB_MAX) ? '0 : sub_y_q + 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            xpos_q    <= X_RESET;
            ypos_q    <= Y_RESET;
            sub_x_q   <= '0;
            sub_y_q   <= '0;
            tcnt_q    <= '0;
            dir_q     <= D_L;
            req_dir_q <= D_L;
            req_v_q   <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
            sub_x_q   <= sub_x_d;
            sub_y_q   <= sub_y_d;
            tcnt_q    <= tcnt_d;
            dir_q     <= dir_d;
            req_dir_q <= req_dir_d;
            req_v_q   <= req_v_d;
            step_q    <= do_step;
        end
    end

    assign bus.xpos      = xpos_q;
    assign bus.ypos      = ypos_q;
    assign bus.dir       = dir_q;
    assign bus.moving    = (state_q == S_MOVING);
    assign bus.step      = step_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_pacman_mover.sv
// tb_pacman_mover
//   Self-checking bench for pacman_mover: a priority vector table, hand-written
//   corner sequences (reset, start, queued turn, wall, reversal, maze edge) and
//   a randomized run, all shadowed cycle-by-cycle by a pixel-level reference
//   model that derives alignment from plain arithmetic on the position.
module tb_pacman_mover;
    localparam int START_X  = 306;
    localparam int START_Y  = 310;
    localparam int ORIGIN_X = 150;
    localparam int ORIGIN_Y = 34;
    localparam int TILE     = 12;
    localparam int COLS     = 28;
    localparam int TICK_DIV = 4;
    localparam int X_LEFT   = ORIGIN_X;
    localparam int X_LAST   = ORIGIN_X + (COLS - 1) * TILE;
    localparam int X_RIGHT  = ORIGIN_X + COLS * TILE - 1;
`ifdef PACMAN_TUNNEL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc_n = 0;
    bit   chk_en = 1'b0;

    pacman_mover_if bus();

    pacman_mover #(
        .START_X(START_X), .START_Y(START_Y), .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y),
        .TILE(TILE), .COLS(COLS), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at 2ms, expected to finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not seen within its cycle budget, expected it (cycle %0d)", name, cyc_n);
    endtask

    // ---------------- reference model ----------------
    int m_x, m_y, m_dir, m_moving, m_step, m_req_v, m_req_dir, m_cyc;

    function automatic bit m_aligned();
        return (((m_x - ORIGIN_X) % TILE) == 0) && (((m_y - ORIGIN_Y) % TILE) == 0);
    endfunction

    function automatic int opposite(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit leg_ok(input int d, input bit al);
        bit ok;
        case (d)
            0: ok = bus.leg_l;
            1: ok = bus.leg_r;
            2: ok = bus.leg_u;
            default: ok = bus.leg_d;
        endcase
        if (!WRAP && al && d == 0 && m_x == X_LEFT) ok = 1'b0;
        if (!WRAP && al && d == 1 && m_x == X_LAST) ok = 1'b0;
        return ok;
    endfunction

    task automatic model_edge();
        bit tick, al, commit, stepped;
        if (reset) begin
            m_x = START_X; m_y = START_Y; m_dir = 0; m_moving = 0; m_step = 0;
            m_req_v = 0; m_req_dir = 0; m_cyc = 0;
            return;
        end
        tick    = (m_cyc % TICK_DIV) == (TICK_DIV - 1);
        al      = m_aligned();
        commit  = 1'b0;
        stepped = 1'b0;
        if (tick) begin
            if (m_moving == 0) begin
                if (m_req_v != 0 && leg_ok(m_req_dir, al)) begin
                    m_dir = m_req_dir; commit = 1'b1; stepped = 1'b1; m_moving = 1;
                end
            end else if (!al) begin
                if (m_req_v != 0 && m_req_dir == opposite(m_dir)) begin
                    m_dir = m_req_dir; commit = 1'b1;
                end
                stepped = 1'b1;
            end else begin
                if (m_req_v != 0 && leg_ok(m_req_dir, al)) begin
                    m_dir = m_req_dir; commit = 1'b1;
                end
                if (leg_ok(m_dir, al)) stepped = 1'b1;
                else                   m_moving = 0;
            end
        end
        if (stepped) begin
            case (m_dir)
                0: m_x = (WRAP && m_x == X_LEFT)  ? X_RIGHT : m_x - 1;
                1: m_x = (WRAP && m_x == X_RIGHT) ? X_LEFT  : m_x + 1;
                2: m_y = m_y - 1;
                default: m_y = m_y + 1;
            endcase
        end
        if (bus.btn_l || bus.btn_r || bus.btn_u || bus.btn_d) begin
            m_req_v   = 1;
            m_req_dir = bus.btn_l ? 0 : bus.btn_r ? 1 : bus.btn_u ? 2 : 3;
        end else if (commit) begin
            m_req_v = 0;
        end
        m_step = stepped ? 1 : 0;
        m_cyc++;
    endtask

    always @(posedge clk) model_edge();

    // ---------------- scoreboard: DUT vs model every cycle ----------------
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("model_xpos", int'(bus.xpos), m_x);
            chk("model_ypos", int'(bus.ypos), m_y);
            chk("model_dir", int'(bus.dir), m_dir);
            chk("model_moving", int'(bus.moving), m_moving);
            chk("model_step", int'(bus.step), m_step);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_btns(input logic [3:0] b);
        {bus.btn_l, bus.btn_r, bus.btn_u, bus.btn_d} = b;
    endtask

    task automatic set_legs(input logic [3:0] l);
        {bus.leg_l, bus.leg_r, bus.leg_u, bus.leg_d} = l;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_btns(4'b0000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] b);
        set_btns(b);
        @(negedge clk);
        set_btns(4'b0000);
    endtask

    task automatic wait_step(input string name, input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bus.step) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail(name);
    endtask

    task automatic wait_x(input string name, input int target, input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (int'(bus.xpos) == target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail(name);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] btns;    // {l, r, u, d}
        int         exp_dir;
        int         exp_x;
        int         exp_y;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int steps_seen;
        int last;
        set_btns(4'b0000);
        set_legs(4'b0000);

        vecs[0] = '{4'b1000, 0, 305, 310};
        vecs[1] = '{4'b0100, 1, 307, 310};
        vecs[2] = '{4'b0010, 2, 306, 309};
        vecs[3] = '{4'b0001, 3, 306, 311};
        vecs[4] = '{4'b1111, 0, 305, 310};
        vecs[5] = '{4'b0111, 1, 307, 310};
        vecs[6] = '{4'b0011, 2, 306, 309};
        vecs[7] = '{4'b1001, 0, 305, 310};

        // Reset: idle for 100 cycles, no step ever.
        do_reset();
        chk_en = 1'b1;
        chk("reset_moving", int'(bus.moving), 0);
        steps_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.step) steps_seen++;
        end
        chk("reset_xpos", int'(bus.xpos), 306);
        chk("reset_ypos", int'(bus.ypos), 310);
        chk("reset_dir", int'(bus.dir), 0);
        chk("reset_moving_idle", int'(bus.moving), 0);
        chk("reset_no_step", steps_seen, 0);

        // Button priority table: one pulse from IDLE with all legs open.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            set_legs(4'b1111);
            pulse(vecs[i].btns);
            wait_step($sformatf("vec%0d_step", i), 20);
            chk($sformatf("vec%0d_dir", i), int'(bus.dir), vecs[i].exp_dir);
            chk($sformatf("vec%0d_x", i), int'(bus.xpos), vecs[i].exp_x);
            chk($sformatf("vec%0d_y", i), int'(bus.ypos), vecs[i].exp_y);
            chk($sformatf("vec%0d_moving", i), int'(bus.moving), 1);
        end

        // Start left: 12 steps, 4 cycles apart, ending aligned at 294.
        do_reset();
        set_legs(4'b1000);
        pulse(4'b1000);
        wait_step("start_first_step", 20);
        chk("start_x1", int'(bus.xpos), 305);
        chk("start_moving", int'(bus.moving), 1);
        last = cyc_n;
        for (int k = 2; k <= 12; k++) begin
            wait_step("start_next_step", 20);
            chk("start_interval", cyc_n - last, TICK_DIV);
            last = cyc_n;
        end
        chk("start_x12", int'(bus.xpos), 294);
        chk("start_aligned", (int'(bus.xpos) - ORIGIN_X) % TILE, 0);

        // Queued turn: request U at sub_x=5, taken only at the next tile edge.
        do_reset();
        set_legs(4'b1010);
        pulse(4'b1000);
        wait_x("queued_reach_299", 299, 100);
        pulse(4'b0010);
        for (int k = 0; k < 5; k++) begin
            wait_step("queued_step", 20);
            chk("queued_dir_hold", int'(bus.dir), 0);
        end
        chk("queued_x_at_edge", int'(bus.xpos), 294);
        wait_step("queued_turn_step", 20);
        chk("queued_dir_up", int'(bus.dir), 2);
        chk("queued_ypos", int'(bus.ypos), 309);
        chk("queued_xpos", int'(bus.xpos), 294);

        // Wall at 294, then leave downward.
        do_reset();
        set_legs(4'b1000);
        pulse(4'b1000);
        wait_x("wall_reach_294", 294, 100);
        set_legs(4'b0000);
        repeat (10) @(negedge clk);
        chk("wall_moving", int'(bus.moving), 0);
        chk("wall_xpos_hold", int'(bus.xpos), 294);
        set_legs(4'b0001);
        pulse(4'b0001);
        wait_step("wall_exit_step", 20);
        chk("wall_exit_ypos", int'(bus.ypos), 311);
        chk("wall_exit_moving", int'(bus.moving), 1);
        chk("wall_exit_xpos", int'(bus.xpos), 294);

        // Mid-tile reversal ignores leg_r.
        do_reset();
        set_legs(4'b1000);
        pulse(4'b1000);
        wait_x("rev_reach_302", 302, 100);
        pulse(4'b0100);
        wait_step("rev_step", 20);
        chk("rev_dir", int'(bus.dir), 1);
        chk("rev_xpos", int'(bus.xpos), 303);

        // Maze left edge.
        do_reset();
        set_legs(4'b1000);
        pulse(4'b1000);
        wait_x("edge_reach_150", 150, 800);
`ifdef PACMAN_TUNNEL_WRAP_EN
        wait_step("tunnel_step", 20);
        chk("tunnel_xpos", int'(bus.xpos), 485);
        chk("tunnel_dir", int'(bus.dir), 0);
`else
        repeat (12) @(negedge clk);
        chk("edge_moving", int'(bus.moving), 0);
        chk("edge_xpos_hold", int'(bus.xpos), 150);
`endif

        // Randomized play, checked against the model every cycle.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i == 2000) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            set_btns({($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
                      ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0)});
            bus.leg_l = ($urandom_range(0, 3) != 0);
            bus.leg_r = ($urandom_range(0, 3) != 0);
            bus.leg_u = ($urandom_range(0, 3) != 0) && (m_y > ORIGIN_Y + TILE);
            bus.leg_d = ($urandom_range(0, 3) != 0) && (m_y < ORIGIN_Y + 29 * TILE);
        end
        set_btns(4'b0000);
        @(negedge clk);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
